// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a bounded hold time.
// Registered one-hot grant plus binary index; the holder is revoked after HOLD_MAX cycles.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grantIdx,
  output logic       grantValid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [7:0] masked_req;
  logic [2:0] pick_all;
  logic [2:0] pick_masked;
  logic [2:0] win;
  logic       hold_at_max;
  logic       load;
  logic       go_idle;
  logic       pulse;

  // First set bit at or above start, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
    logic [2:0] pick;
    logic [2:0] k;
    logic       hit;
    pick = start;
    hit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = start + 3'(i);
      if (!hit && v[k]) begin
        pick = k;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  assign hold_at_max = (hold_cnt >= 8'(HOLD_MAX));

  // In GRANT, grant holds only the current holder, so masking by grant drops it.
  always_comb begin
    masked_req  = req & ~grant;
    pick_all    = rr_pick(req, ptr);
    pick_masked = (masked_req != 8'd0) ? rr_pick(masked_req, ptr) : grantIdx;
    win         = pick_all;
    load        = 1'b0;
    go_idle     = 1'b0;
    pulse       = 1'b0;
    case (state)
      IDLE: load = (req != 8'd0);
      GRANT: begin
        if (!req[grantIdx]) begin
          load    = (req != 8'd0);
          go_idle = (req == 8'd0);
        end else if (hold_at_max) begin
          load  = 1'b1;
          pulse = 1'b1;
          win   = pick_masked;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      hold_cnt   <= 8'd0;
      grant      <= 8'd0;
      grantIdx   <= 3'd0;
      grantValid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= pulse;
      if (load) begin
        state      <= GRANT;
        grant      <= 8'd1 << win;
        grantIdx   <= win;
        grantValid <= 1'b1;
        hold_cnt   <= 8'd1;
        ptr        <= win + 3'd1;
      end else if (go_idle) begin
        state      <= IDLE;
        grant      <= 8'd0;
        grantIdx   <= 3'd0;
        grantValid <= 1'b0;
        hold_cnt   <= 8'd0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 with HOLD_MAX=4: directed scenarios plus random
// traffic compared against a behavioural round-robin model.
module tb_rr_arbiter_8;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grantIdx;
  logic       grantValid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grantIdx(grantIdx), .grantValid(grantValid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the resource, for how long, and where the next search starts.
  int m_ptr = 0, m_holder = 0, m_hold = 0;
  bit m_valid = 0, m_timeout = 0;

  function automatic int model_pick(input logic [7:0] v, input int start);
    for (int k = 0; k < 8; k++)
      if (v[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_valid  = 1;
    m_holder = w;
    m_hold   = 1;
    m_ptr    = (w + 1) % 8;
  endtask

  always @(posedge clk) begin
    logic [7:0] others;
    if (rst) begin
      m_ptr = 0; m_holder = 0; m_hold = 0; m_valid = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      if (!m_valid) begin
        if (req != 0) model_grant(model_pick(req, m_ptr));
      end else if (!req[m_holder]) begin
        if (req != 0) model_grant(model_pick(req, m_ptr));
        else begin m_valid = 0; m_holder = 0; m_hold = 0; end
      end else if (m_hold < HOLD) begin
        m_hold++;
      end else begin
        m_timeout = 1;
        others = req;
        others[m_holder] = 1'b0;
        model_grant(others != 0 ? model_pick(others, m_ptr) : m_holder);
      end
    end
  end

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    g = m_valid ? (8'h01 << m_holder) : 8'h00;
    return {g, m_valid ? 3'(m_holder) : 3'd0, m_valid, m_timeout};
  endfunction

  function automatic logic [12:0] dut_out();
    return {grant, grantIdx, grantValid, timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_out() !== 13'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle=%0d out=%h expected=%h", i, dut_out(), 13'h0);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut_out() !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_first_grant out=%h expected=%h", dut_out(), {8'h01, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20;
    tick();
    checks++;
    if (dut_out() !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL single_grant out=%h expected=%h", dut_out(), {8'h20, 3'd5, 1'b1, 1'b0});
    end
    req = 8'h00;
    tick();
    checks++;
    if (dut_out() !== 13'h0) begin
      failures++;
      $display("[TB] FAIL single_release out=%h expected=%h", dut_out(), 13'h0);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] cur;
    do_reset();
    req = 8'hFF;
    tick();
    cur = 8'h01;
    checks++;
    if (grantIdx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL rr_start idx=%0d expected=0", grantIdx);
    end
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~cur;
      tick();
      req = 8'hFF;
      cur = 8'h01 << (k % 8);
      checks++;
      if (grantIdx !== 3'(k % 8) || grant !== cur) begin
        failures++;
        $display("[TB] FAIL rr_step k=%0d idx=%0d grant=%h expected idx=%0d grant=%h",
                 k, grantIdx, grant, k % 8, cur);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] eg;
    logic       et;
    do_reset();
    req = 8'h0A;
    for (int c = 1; c <= 12; c++) begin
      tick();
      eg = (((c - 1) / HOLD) % 2 == 1) ? 8'h08 : 8'h02;
      et = (c > 1) && ((c - 1) % HOLD == 0);
      checks++;
      if (grant !== eg || timeout !== et) begin
        failures++;
        $display("[TB] FAIL timeout_pair c=%0d grant=%h timeout=%b expected grant=%h timeout=%b",
                 c, grant, timeout, eg, et);
      end
    end
  endtask

  task automatic test_sole_timeout();
    logic et;
    do_reset();
    req = 8'h80;
    for (int c = 1; c <= 12; c++) begin
      tick();
      et = (c > 1) && ((c - 1) % HOLD == 0);
      checks++;
      if (grant !== 8'h80 || grantIdx !== 3'd7 || timeout !== et) begin
        failures++;
        $display("[TB] FAIL sole_timeout c=%0d grant=%h timeout=%b expected grant=80 timeout=%b",
                 c, grant, timeout, et);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 8'h08;
    tick();
    checks++;
    if (grantIdx !== 3'd3) begin
      failures++;
      $display("[TB] FAIL mid_reset_setup idx=%0d expected=3", grantIdx);
    end
    rst = 1'b1;
    req = 8'hFF;
    tick();
    checks++;
    if (dut_out() !== 13'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_clear out=%h expected=%h", dut_out(), 13'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 8'h01) begin
      failures++;
      $display("[TB] FAIL mid_reset_ptr grant=%h expected=01", grant);
    end
  endtask

  task automatic test_release_on_timeout();
    do_reset();
    req = 8'h06;
    for (int c = 1; c <= HOLD; c++) tick();
    checks++;
    if (grant !== 8'h02 || timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_setup grant=%h timeout=%b expected grant=02 timeout=0", grant, timeout);
    end
    req = 8'h04;
    tick();
    checks++;
    if (grant !== 8'h04 || timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_beats_timeout grant=%h timeout=%b expected grant=04 timeout=0",
               grant, timeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'h01 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("[TB] FAIL random i=%0d req=%h out=%h expected=%h", i, req, dut_out(), model_out());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_sole_timeout();
    test_mid_reset();
    test_release_on_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
